// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Controller state: normal issue, data-memory freeze, wrong-path flush window.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hz_state_e;

    // Architectural zero register; writes to it are discarded, so it never forwards.
    localparam logic [4:0] REG_X0 = 5'd0;

    // True when an ID source operand is actually read and names the given register.
    function automatic logic src_hit(input logic [4:0] rs, input logic uses, input logic [4:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Stall and flush performance counters; both wrap modulo 2^CNT_W.
module hazard_perf_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Count stalled cycles and accepted branch flush events.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_inc) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and data-memory freezes.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout_err
);

    // Remaining flush cycles after the one spent in RUN accepting the branch.
    localparam logic [3:0]  FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

    hz_state_e   state_q, state_d;
    logic [3:0]  flush_left_q, flush_left_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    logic load_use;
    logic mem_wait;
    logic branch_accept;

    assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                      (src_hit(id_rs1, id_uses_rs1, ex_rd) || src_hit(id_rs2, id_uses_rs2, ex_rd));
    assign mem_wait = mem_req && !mem_ready;

    // A branch is taken up only outside the flush window and when the pipe is not frozen.
    assign branch_accept = !reset && ex_branch_taken && !mem_wait && (state_q != FLUSH);

    // State, flush window and memory-wait tracking registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            flush_left_q  <= '0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_left_q  <= flush_left_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic; MEM_WAIT re-evaluates everything like RUN once memory is ready.
    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_wait) begin
                    state_d = MEM_WAIT;
                end else if (ex_branch_taken && (FLUSH_CYCLES > 1)) begin
                    state_d      = FLUSH;
                    flush_left_d = FLUSH_LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                // The window is frozen while memory stalls the pipe.
                if (!mem_wait) begin
                    if (flush_left_q <= 4'd1) begin
                        flush_left_d = '0;
                        state_d      = RUN;
                    end else begin
                        flush_left_d = flush_left_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d      = RUN;
                flush_left_d = '0;
            end
        endcase
    end

    // Consecutive memory-wait counter (saturating) and sticky timeout flag.
    always_comb begin
        wait_cnt_d    = '0;
        timeout_err_d = timeout_err_q;
        if (mem_wait) begin
            wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
            if (wait_cnt_d >= TIMEOUT_VAL) begin
                timeout_err_d = 1'b1;
            end
        end
    end

    // Mealy control outputs; forced low while reset is asserted.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN, MEM_WAIT: begin
                    if (mem_wait) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                    end else if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    // ID/EX keeps flushing instead of holding: its content is wrong-path
                    // anyway, and the register would drop a held value under flush.
                    if (mem_wait) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_timeout_err = timeout_err_q;

    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf_counters (
        .clk       (clk),
        .reset     (reset),
        .stall_inc (pc_stall),
        .flush_inc (branch_accept),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with FLUSH_CYCLES=2, MEM_TIMEOUT=3.
module tb_hazard_ctrl_unit;

    localparam int unsigned CNT_W = 32;

    // Control vector order: pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall.
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110010;
    localparam logic [5:0] C_MW   = 6'b110101;
    localparam logic [5:0] C_BR   = 6'b001010;
    localparam logic [5:0] C_FMW  = 6'b111011;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic             ex_branch_taken, mem_req, mem_ready;
    logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_timeout_err;
    logic [5:0]       ctrl;

    int checks = 0;
    int errors = 0;

    assign ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall};

    hazard_ctrl_unit #(
        .FLUSH_CYCLES (2),
        .MEM_TIMEOUT  (3),
        .CNT_W        (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_stall     (id_ex_stall),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_stall    (ex_mem_stall),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .mem_timeout_err (mem_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the falling edge, apply one cycle of inputs, let the Mealy outputs settle.
    task automatic drive(input logic rst, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic br, input logic mreq, input logic mrdy);
        @(negedge clk);
        reset           = rst;
        ex_mem_read     = mr;
        ex_rd           = rd;
        id_rs1          = rs1;
        id_uses_rs1     = u1;
        id_rs2          = rs2;
        id_uses_rs2     = u2;
        ex_branch_taken = br;
        mem_req         = mreq;
        mem_ready       = mrdy;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Load in EX writing x5, ID reads x5 through rs1.
    task automatic lu(input logic br, input logic mreq, input logic mrdy);
        drive(1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, br, mreq, mrdy);
    endtask

    initial begin
        reset = 1'b1;
        ex_mem_read = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        // Outputs stay low during reset even with every hazard present.
        drive(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("reset_ctrl", 32'(ctrl), 32'(C_NONE));
        idle();
        check("post_reset_ctrl", 32'(ctrl), 32'(C_NONE));
        check("post_reset_stall_cnt", stall_cnt, 32'd0);
        check("post_reset_flush_cnt", flush_cnt, 32'd0);
        check("post_reset_err", 32'(mem_timeout_err), 32'd0);

        // Load-use on rs1: one bubble cycle.
        lu(1'b0, 1'b0, 1'b0);
        check("lu_rs1_ctrl", 32'(ctrl), 32'(C_LU));
        idle();
        check("lu_done_ctrl", 32'(ctrl), 32'(C_NONE));
        check("lu_stall_cnt", stall_cnt, 32'd1);

        // x0 destination and an unused matching rs2 never stall.
        drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("x0_ctrl", 32'(ctrl), 32'(C_NONE));
        drive(1'b0, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        check("unused_rs2_ctrl", 32'(ctrl), 32'(C_NONE));
        check("unused_rs2_stall_cnt", stall_cnt, 32'd1);
        drive(1'b0, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu_rs2_ctrl", 32'(ctrl), 32'(C_LU));

        // Memory wait for 4 cycles with a load-use also pending: freeze only, no flush.
        for (int i = 0; i < 4; i++) begin
            lu(1'b0, 1'b1, 1'b0);
            check($sformatf("mw_ctrl_%0d", i), 32'(ctrl), 32'(C_MW));
            check($sformatf("mw_err_%0d", i), 32'(mem_timeout_err), (i == 3) ? 32'd1 : 32'd0);
        end
        check("mw_stall_cnt", stall_cnt, 32'd5);
        // Ready cycle: freeze drops and the pending load-use is seen in the same cycle.
        lu(1'b0, 1'b1, 1'b1);
        check("mw_ready_ctrl", 32'(ctrl), 32'(C_LU));
        check("mw_ready_stall_cnt", stall_cnt, 32'd6);
        idle();
        check("mw_after_ctrl", 32'(ctrl), 32'(C_NONE));
        check("mw_after_stall_cnt", stall_cnt, 32'd7);
        check("err_sticky", 32'(mem_timeout_err), 32'd1);

        // Reset clears the sticky error and the counters.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset2_ctrl", 32'(ctrl), 32'(C_NONE));
        idle();
        check("reset2_err", 32'(mem_timeout_err), 32'd0);
        check("reset2_stall_cnt", stall_cnt, 32'd0);

        // Taken branch with a simultaneous load-use: two flush cycles, no stall.
        lu(1'b1, 1'b0, 1'b0);
        check("br_ctrl_0", 32'(ctrl), 32'(C_BR));
        lu(1'b0, 1'b0, 1'b0);
        check("br_ctrl_1", 32'(ctrl), 32'(C_BR));
        check("br_flush_cnt", flush_cnt, 32'd1);
        check("br_stall_cnt", stall_cnt, 32'd0);
        lu(1'b0, 1'b0, 1'b0);
        check("br_end_ctrl", 32'(ctrl), 32'(C_LU));
        idle();
        check("br_idle_ctrl", 32'(ctrl), 32'(C_NONE));

        // Branch, then a second branch plus memory wait inside the flush window.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("br2_ctrl", 32'(ctrl), 32'(C_BR));
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("flush_mw_ctrl", 32'(ctrl), 32'(C_FMW));
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("flush_frozen_ctrl", 32'(ctrl), 32'(C_BR));
        idle();
        check("flush_exit_ctrl", 32'(ctrl), 32'(C_NONE));
        check("flush_ignored_cnt", flush_cnt, 32'd2);
        check("flush_mw_stall_cnt", stall_cnt, 32'd2);

        // Reset in the middle of a memory wait.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("mw2_ctrl_0", 32'(ctrl), 32'(C_MW));
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("mw2_ctrl_1", 32'(ctrl), 32'(C_MW));
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("mw2_reset_ctrl", 32'(ctrl), 32'(C_NONE));
        idle();
        check("mw2_after_ctrl", 32'(ctrl), 32'(C_NONE));
        check("mw2_after_stall_cnt", stall_cnt, 32'd0);
        check("mw2_after_flush_cnt", flush_cnt, 32'd0);
        check("mw2_after_err", 32'(mem_timeout_err), 32'd0);
        lu(1'b0, 1'b0, 1'b0);
        check("mw2_run_lu_ctrl", 32'(ctrl), 32'(C_LU));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
